// File: rtl/led_display_pkg.sv
// Shared game definitions for the LED display: feedback state encoding and LED geometry.
// No logic here; imported by the display block.
package led_display_pkg;

  localparam int LED_COUNT = 8;
  localparam int LED_IDX_W = $clog2(LED_COUNT);

  typedef enum logic [1:0] {
    SHOW_MOLE = 2'd0,
    RIGHT     = 2'd1,
    WRONG     = 2'd2
  } led_state_t;

endpackage

// File: rtl/led_display_blink_timer.sv
// Blink phase generator: phase flips every BLINK_CYCLES cycles, restarts high on clear.
// phase_next is the value the phase register takes at the coming edge; no backpressure.
module blink_timer #(
  parameter int BLINK_CYCLES = 6_250_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic phase_next
);

  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          phase;

  // Exposing the next phase lets the parent load its LED register on the same edge.
  always_comb begin
    cnt_next   = cnt + 1'b1;
    phase_next = phase;
    if (i_clr) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (cnt == CW'(BLINK_CYCLES - 1)) begin
      cnt_next   = '0;
      phase_next = ~phase;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/led_display.sv
// Whack-a-mole LED driver: shows the mole, or a timed right/wrong blink pattern after a score pulse.
// leds registered, one-cycle latency from inputs; always accepts events, retrigger restarts feedback.
module led_display
  import led_display_pkg::*;
#(
  parameter int FEEDBACK_CYCLES = 50_000_000,
  parameter int BLINK_CYCLES    = 6_250_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [LED_IDX_W-1:0] i_user_guess,
  input  logic [LED_IDX_W-1:0] i_mole_position,
  input  logic                 i_user_right,
  input  logic                 i_user_wrong,
  output logic [LED_COUNT-1:0] leds
);

  localparam int FW = $clog2(FEEDBACK_CYCLES);

  led_state_t           state;
  logic [FW-1:0]        fb_cnt;
  logic [LED_IDX_W-1:0] guess_q;
  logic [LED_IDX_W-1:0] mole_q;
  logic                 event_hit;
  logic                 phase_next;

  logic [LED_COUNT-1:0] live_mole_oh;
  logic [LED_COUNT-1:0] live_guess_oh;
  logic [LED_COUNT-1:0] held_mole_oh;
  logic [LED_COUNT-1:0] held_guess_oh;

  assign event_hit     = i_user_right | i_user_wrong;
  assign live_mole_oh  = LED_COUNT'(1) << i_mole_position;
  assign live_guess_oh = LED_COUNT'(1) << i_user_guess;
  assign held_mole_oh  = LED_COUNT'(1) << mole_q;
  assign held_guess_oh = LED_COUNT'(1) << guess_q;

  blink_timer #(
    .BLINK_CYCLES (BLINK_CYCLES)
  ) u_blink (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (event_hit),
    .phase_next (phase_next)
  );

  // leds is loaded from the state being entered, so every pattern change shows right after its edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= SHOW_MOLE;
      fb_cnt  <= '0;
      guess_q <= '0;
      mole_q  <= '0;
      leds    <= '0;
    end else if (i_user_right) begin
      state   <= RIGHT;
      fb_cnt  <= '0;
      guess_q <= i_user_guess;
      mole_q  <= i_mole_position;
      leds    <= '1;
    end else if (i_user_wrong) begin
      state   <= WRONG;
      fb_cnt  <= '0;
      guess_q <= i_user_guess;
      mole_q  <= i_mole_position;
      leds    <= live_mole_oh | live_guess_oh;
    end else begin
      case (state)
        RIGHT, WRONG: begin
          if (fb_cnt == FW'(FEEDBACK_CYCLES - 1)) begin
            state  <= SHOW_MOLE;
            fb_cnt <= '0;
            leds   <= live_mole_oh;
          end else begin
            fb_cnt <= fb_cnt + 1'b1;
            if (state == RIGHT)
              leds <= {LED_COUNT{phase_next}};
            else
              leds <= held_mole_oh | (held_guess_oh & {LED_COUNT{phase_next}});
          end
        end
        default: begin
          state <= SHOW_MOLE;
          leds  <= live_mole_oh;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_display.sv
// Directed plus randomized bench for led_display, checked against a cycle-indexed behavioural model.
module tb_led_display;

  localparam int FB = 100;
  localparam int BL = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] user_guess = '0;
  logic [2:0] mole = '0;
  logic       user_right = 1'b0;
  logic       user_wrong = 1'b0;
  logic [7:0] leds;

  int total = 0;
  int bad   = 0;

  // Model: mode 0 idle, 1 right, 2 wrong; k = cycles since the entry edge.
  int         m_mode = 0;
  int         m_k    = 0;
  logic [2:0] m_g    = '0;
  logic [2:0] m_m    = '0;

  led_display #(
    .FEEDBACK_CYCLES (FB),
    .BLINK_CYCLES    (BL)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_user_guess    (user_guess),
    .i_mole_position (mole),
    .i_user_right    (user_right),
    .i_user_wrong    (user_wrong),
    .leds            (leds)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_leds(input logic [2:0] cur_mole);
    logic       ph;
    logic [7:0] res;
    ph = ((m_k / BL) % 2) == 0;
    if (m_mode == 1)
      res = ph ? 8'hFF : 8'h00;
    else if (m_mode == 2)
      res = (8'd1 << m_m) | (ph ? (8'd1 << m_g) : 8'h00);
    else
      res = 8'd1 << cur_mole;
    return res;
  endfunction

  task automatic check(input string tag, input logic [7:0] exp);
    total++;
    assert (leds === exp) else begin
      bad++;
      $error("FAIL %s: leds=%02h expected=%02h", tag, leds, exp);
    end
  endtask

  // Called at a negedge: drive inputs, take one rising edge, compare against the model.
  task automatic step(input logic r, input logic w, input logic [2:0] g,
                      input logic [2:0] m, input string tag);
    user_right = r;
    user_wrong = w;
    user_guess = g;
    mole       = m;
    @(posedge clk);
    if (r) begin
      m_mode = 1; m_k = 0; m_g = g; m_m = m;
    end else if (w) begin
      m_mode = 2; m_k = 0; m_g = g; m_m = m;
    end else if (m_mode != 0) begin
      m_k++;
      if (m_k == FB) begin
        m_mode = 0;
        m_k    = 0;
      end
    end
    #1 check(tag, model_leds(m));
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1 check(tag, 8'h00);
    m_mode = 0; m_k = 0; m_g = '0; m_m = '0;
    @(posedge clk);
    #1 check({tag, "_held"}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic       r, w;
    logic [2:0] g, m;

    // 1. Reset
    #2 rst = 1'b1;
    #1 check("reset_async", 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0, "post_reset_mole0");
    check("post_reset_const", 8'h01);

    // 2. Idle tracking
    step(0, 0, 0, 3, "idle_mole3");
    check("idle_mole3_const", 8'h08);
    step(0, 0, 0, 7, "idle_mole7");
    check("idle_mole7_const", 8'h80);

    // 3. Wrong pattern, then exit shows the current mole
    step(0, 1, 0, 3, "wrong_entry");
    check("wrong_entry_const", 8'h09);
    for (int i = 1; i < FB; i++) begin
      step(0, 0, 0, 3, "wrong_run");
      if (i == 10) check("wrong_off_const", 8'h08);
    end
    step(0, 0, 0, 5, "wrong_exit");
    check("wrong_exit_const", 8'h20);

    // 4. Right pattern
    step(1, 0, 0, 3, "right_entry");
    check("right_entry_const", 8'hFF);
    for (int i = 1; i < FB; i++) begin
      step(0, 0, 0, 3, "right_run");
      if (i == 15) check("right_off_const", 8'h00);
    end
    step(0, 0, 0, 3, "right_exit");
    check("right_exit_const", 8'h08);

    // 5. Priority, then retrigger 50 cycles into RIGHT
    step(1, 1, 0, 3, "both_pulse");
    check("both_pulse_const", 8'hFF);
    for (int i = 1; i < 50; i++) step(0, 0, 0, 3, "retrig_right_run");
    step(0, 1, 2, 3, "retrig_wrong");
    check("retrig_wrong_const", 8'h0C);
    for (int i = 1; i < FB; i++) step(0, 0, 2, 3, "retrig_wrong_run");
    check("retrig_still_wrong", 8'h08);
    step(0, 0, 2, 3, "retrig_exit");

    // 6. Latching and reset mid-pattern
    step(0, 1, 1, 3, "latch_entry");
    for (int i = 1; i < 16; i++) step(0, 0, 6, 5, "latch_run");
    check("latch_const", 8'h08);
    do_reset("reset_mid");
    step(0, 0, 0, 4, "after_mid_reset");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset("rand_reset");
      end else begin
        r = ($urandom_range(0, 59) == 0);
        w = ($urandom_range(0, 49) == 0);
        g = 3'($urandom_range(0, 7));
        m = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : mole;
        step(r, w, g, m, "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
